// File: rtl/mano_param_reg.sv
// Parametrised Mano basic-computer register: clear, load, increment, decrement, carry and zero flags.
// Optional shift-left/shift-right is enabled with the MANO_REG_SHIFT_EN macro.
module mano_param_reg #(
  parameter int          WIDTH       = 16,
  parameter logic [63:0] RESET_VALUE = 64'd0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CLR,
  input  logic             LD,
  input  logic             INR,
  input  logic             DCR,
  input  logic             SHR,
  input  logic             SHL,
  input  logic             SIN,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             CO,
  output logic             ZERO
);

  logic [WIDTH-1:0] q_reg;
  logic             co_reg;
  logic [WIDTH:0]   inc_sum;
  logic [WIDTH:0]   dec_sum;

  // The extra top bit of each sum is the carry (increment) or borrow (decrement).
  assign inc_sum = {1'b0, q_reg} + {{WIDTH{1'b0}}, 1'b1};
  assign dec_sum = {1'b0, q_reg} - {{WIDTH{1'b0}}, 1'b1};

`ifdef MANO_REG_SHIFT_EN
  logic [WIDTH-1:0] shr_val;
  logic [WIDTH-1:0] shl_val;

  generate
    if (WIDTH == 1) begin : g_shift_w1
      assign shr_val = SIN;
      assign shl_val = SIN;
    end else begin : g_shift_wn
      assign shr_val = {SIN, q_reg[WIDTH-1:1]};
      assign shl_val = {q_reg[WIDTH-2:0], SIN};
    end
  endgenerate
`else
  // Shift ports exist for interface compatibility only.
  logic unused_shift;
  assign unused_shift = ^{SHR, SHL, SIN};
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      q_reg  <= RESET_VALUE[WIDTH-1:0];
      co_reg <= 1'b0;
    end else if (CLR) begin
      q_reg  <= '0;
      co_reg <= 1'b0;
    end else if (LD) begin
      q_reg  <= D;
      co_reg <= 1'b0;
    end else if (INR) begin
      q_reg  <= inc_sum[WIDTH-1:0];
      co_reg <= inc_sum[WIDTH];
    end else if (DCR) begin
      q_reg  <= dec_sum[WIDTH-1:0];
      co_reg <= dec_sum[WIDTH];
`ifdef MANO_REG_SHIFT_EN
    end else if (SHR) begin
      q_reg  <= shr_val;
      co_reg <= q_reg[0];
    end else if (SHL) begin
      q_reg  <= shl_val;
      co_reg <= q_reg[WIDTH-1];
`endif
    end
  end

  assign Q    = q_reg;
  assign CO   = co_reg;
  assign ZERO = (q_reg == '0);

endmodule

// File: tb/tb_mano_param_reg.sv
// Self-checking bench for mano_param_reg: directed scenarios plus random commands against a rule-level model.
// Three instances share stimulus: 16-bit reset 0, 16-bit reset 0x0010, and 1-bit reset 1.
module tb_mano_param_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b0, clr = 1'b0, ld = 1'b0, inr = 1'b0, dcr = 1'b0;
  logic        shr = 1'b0, shl = 1'b0, sin = 1'b0;
  logic [15:0] d = '0;

  logic [15:0] q_a, q_b;
  logic        q_c;
  logic        co_a, co_b, co_c, zero_a, zero_b, zero_c;

  int errors = 0;
  int checks = 0;

  logic [63:0] mq  [3];
  logic        mco [3];
  int          mw  [3];
  logic [63:0] mrv [3];

  logic [63:0] obs_q  [3];
  logic        obs_co [3];
  logic        obs_z  [3];

  assign obs_q[0] = {48'd0, q_a};
  assign obs_q[1] = {48'd0, q_b};
  assign obs_q[2] = {63'd0, q_c};
  assign obs_co[0] = co_a;
  assign obs_co[1] = co_b;
  assign obs_co[2] = co_c;
  assign obs_z[0] = zero_a;
  assign obs_z[1] = zero_b;
  assign obs_z[2] = zero_c;

  always #5 clk = ~clk;

  mano_param_reg #(.WIDTH(16), .RESET_VALUE(64'h0)) dut_a (
    .CLK(clk), .RESET(rst), .CLR(clr), .LD(ld), .INR(inr), .DCR(dcr),
    .SHR(shr), .SHL(shl), .SIN(sin), .D(d), .Q(q_a), .CO(co_a), .ZERO(zero_a)
  );

  mano_param_reg #(.WIDTH(16), .RESET_VALUE(64'h0010)) dut_b (
    .CLK(clk), .RESET(rst), .CLR(clr), .LD(ld), .INR(inr), .DCR(dcr),
    .SHR(shr), .SHL(shl), .SIN(sin), .D(d), .Q(q_b), .CO(co_b), .ZERO(zero_b)
  );

  mano_param_reg #(.WIDTH(1), .RESET_VALUE(64'h1)) dut_c (
    .CLK(clk), .RESET(rst), .CLR(clr), .LD(ld), .INR(inr), .DCR(dcr),
    .SHR(shr), .SHL(shl), .SIN(sin), .D(d[0]), .Q(q_c), .CO(co_c), .ZERO(zero_c)
  );

  // Rule-level model: value arithmetic with an explicit modulus mask.
  function automatic void model_step(int i);
    logic [63:0] mask;
    mask = (64'd1 << mw[i]) - 64'd1;
    if (rst) begin
      mq[i] = mrv[i] & mask; mco[i] = 1'b0;
    end else if (clr) begin
      mq[i] = 64'd0; mco[i] = 1'b0;
    end else if (ld) begin
      mq[i] = {48'd0, d} & mask; mco[i] = 1'b0;
    end else if (inr) begin
      mco[i] = (mq[i] == mask);
      mq[i]  = (mq[i] + 64'd1) & mask;
    end else if (dcr) begin
      mco[i] = (mq[i] == 64'd0);
      mq[i]  = (mq[i] - 64'd1) & mask;
`ifdef MANO_REG_SHIFT_EN
    end else if (shr) begin
      mco[i] = mq[i][0];
      mq[i]  = (mq[i] >> 1) | (sin ? (64'd1 << (mw[i] - 1)) : 64'd0);
    end else if (shl) begin
      mco[i] = mq[i][mw[i] - 1];
      mq[i]  = ((mq[i] << 1) | {63'd0, sin}) & mask;
`endif
    end
  endfunction

  // Apply one cycle of commands, advance the model, sample 1 ns after the edge.
  task automatic drive(input logic [7:0] cmd, input logic [15:0] dv);
    {rst, clr, ld, inr, dcr, shr, shl, sin} = cmd;
    d = dv;
    for (int i = 0; i < 3; i++) model_step(i);
    @(posedge clk);
    #1;
    {rst, clr, ld, inr, dcr, shr, shl, sin} = 8'h00;
  endtask

  localparam logic [7:0] C_RST = 8'h80, C_CLR = 8'h40, C_LD = 8'h20, C_INR = 8'h10;
  localparam logic [7:0] C_DCR = 8'h08, C_SHR = 8'h04, C_SHL = 8'h02, C_SIN = 8'h01;

  task automatic test_reset();
    drive(C_RST, 16'h0);
    checks += 4;
    if (q_a !== 16'h0000) begin errors++; $display("FAIL reset_q got=%h exp=0000", q_a); end
    if (co_a !== 1'b0) begin errors++; $display("FAIL reset_co got=%b exp=0", co_a); end
    if (zero_a !== 1'b1) begin errors++; $display("FAIL reset_zero got=%b exp=1", zero_a); end
    if (q_b !== 16'h0010) begin errors++; $display("FAIL reset_q_b got=%h exp=0010", q_b); end
    $display("reset: q_a=%h co=%b zero=%b q_b=%h", q_a, co_a, zero_a, q_b);
  endtask

  task automatic test_load();
    drive(C_LD, 16'h1234);
    checks += 3;
    if (q_a !== 16'h1234) begin errors++; $display("FAIL load_q got=%h exp=1234", q_a); end
    if (zero_a !== 1'b0) begin errors++; $display("FAIL load_zero got=%b exp=0", zero_a); end
    if (co_a !== 1'b0) begin errors++; $display("FAIL load_co got=%b exp=0", co_a); end
    $display("load: q=%h co=%b zero=%b", q_a, co_a, zero_a);
  endtask

  task automatic test_increment_wrap();
    drive(C_LD, 16'hFFFE);
    drive(C_INR, 16'h0);
    checks += 2;
    if (q_a !== 16'hFFFF) begin errors++; $display("FAIL inr1_q got=%h exp=FFFF", q_a); end
    if (co_a !== 1'b0) begin errors++; $display("FAIL inr1_co got=%b exp=0", co_a); end
    drive(C_INR, 16'h0);
    checks += 3;
    if (q_a !== 16'h0000) begin errors++; $display("FAIL inr2_q got=%h exp=0000", q_a); end
    if (co_a !== 1'b1) begin errors++; $display("FAIL inr2_co got=%b exp=1", co_a); end
    if (zero_a !== 1'b1) begin errors++; $display("FAIL inr2_zero got=%b exp=1", zero_a); end
    drive(8'h00, 16'hBEEF);
    checks += 2;
    if (q_a !== 16'h0000) begin errors++; $display("FAIL hold_q got=%h exp=0000", q_a); end
    if (co_a !== 1'b1) begin errors++; $display("FAIL hold_co got=%b exp=1", co_a); end
    $display("increment wrap: q=%h co=%b zero=%b", q_a, co_a, zero_a);
  endtask

  task automatic test_decrement_wrap();
    drive(C_CLR, 16'h0);
    drive(C_DCR, 16'h0);
    checks += 2;
    if (q_a !== 16'hFFFF) begin errors++; $display("FAIL dcr1_q got=%h exp=FFFF", q_a); end
    if (co_a !== 1'b1) begin errors++; $display("FAIL dcr1_co got=%b exp=1", co_a); end
    drive(C_DCR, 16'h0);
    checks += 2;
    if (q_a !== 16'hFFFE) begin errors++; $display("FAIL dcr2_q got=%h exp=FFFE", q_a); end
    if (co_a !== 1'b0) begin errors++; $display("FAIL dcr2_co got=%b exp=0", co_a); end
    $display("decrement wrap: q=%h co=%b", q_a, co_a);
  endtask

  task automatic test_priority();
    drive(C_LD, 16'h00FF);
    drive(C_CLR | C_LD | C_INR, 16'hABCD);
    checks += 1;
    if (q_a !== 16'h0000) begin errors++; $display("FAIL prio_clr_q got=%h exp=0000", q_a); end
    drive(C_LD | C_INR | C_DCR, 16'hABCD);
    checks += 2;
    if (q_a !== 16'hABCD) begin errors++; $display("FAIL prio_ld_q got=%h exp=ABCD", q_a); end
    if (co_a !== 1'b0) begin errors++; $display("FAIL prio_ld_co got=%b exp=0", co_a); end
    $display("priority: q=%h co=%b", q_a, co_a);
  endtask

  task automatic test_sync_reset();
    drive(C_LD, 16'h5555);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    drive(8'h00, 16'h0);
    checks += 1;
    if (q_b !== 16'h5555) begin errors++; $display("FAIL glitch_rst_q got=%h exp=5555", q_b); end
    drive(C_RST | C_INR, 16'h0);
    checks += 3;
    if (q_b !== 16'h0010) begin errors++; $display("FAIL rst_inr_q got=%h exp=0010", q_b); end
    if (co_b !== 1'b0) begin errors++; $display("FAIL rst_inr_co got=%b exp=0", co_b); end
    if (zero_b !== 1'b0) begin errors++; $display("FAIL rst_inr_zero got=%b exp=0", zero_b); end
    $display("sync reset: q_b=%h co=%b", q_b, co_b);
  endtask

  task automatic test_shift();
    logic [15:0] e1, e2;
    logic        c1, c2;
`ifdef MANO_REG_SHIFT_EN
    e1 = 16'hC000; c1 = 1'b1; e2 = 16'h8000; c2 = 1'b1;
`else
    e1 = 16'h8001; c1 = 1'b0; e2 = 16'h8001; c2 = 1'b0;
`endif
    drive(C_LD, 16'h8001);
    drive(C_SHR | C_SIN, 16'h0);
    checks += 2;
    if (q_a !== e1) begin errors++; $display("FAIL shr_q got=%h exp=%h", q_a, e1); end
    if (co_a !== c1) begin errors++; $display("FAIL shr_co got=%b exp=%b", co_a, c1); end
    drive(C_SHL, 16'h0);
    checks += 2;
    if (q_a !== e2) begin errors++; $display("FAIL shl_q got=%h exp=%h", q_a, e2); end
    if (co_a !== c2) begin errors++; $display("FAIL shl_co got=%b exp=%b", co_a, c2); end
    $display("shift: q=%h co=%b", q_a, co_a);
  endtask

  task automatic test_random();
    logic [7:0]  cmd;
    logic [15:0] dv;
    for (int n = 0; n < 400; n++) begin
      cmd = 8'h00;
      cmd[7] = ($urandom_range(0, 39) == 0);
      cmd[6] = ($urandom_range(0, 15) == 0);
      cmd[5] = ($urandom_range(0, 5) == 0);
      cmd[4] = ($urandom_range(0, 2) == 0);
      cmd[3] = ($urandom_range(0, 2) == 0);
      cmd[2] = ($urandom_range(0, 3) == 0);
      cmd[1] = ($urandom_range(0, 3) == 0);
      cmd[0] = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: dv = 16'hFFFF;
        1: dv = 16'hFFFE;
        2: dv = 16'h0001;
        3: dv = 16'h0000;
        default: dv = 16'($urandom);
      endcase
      drive(cmd, dv);
      for (int i = 0; i < 3; i++) begin
        checks += 3;
        if (obs_q[i] !== mq[i]) begin
          errors++; $display("FAIL rand_q inst=%0d cyc=%0d got=%h exp=%h", i, n, obs_q[i], mq[i]);
        end
        if (obs_co[i] !== mco[i]) begin
          errors++; $display("FAIL rand_co inst=%0d cyc=%0d got=%b exp=%b", i, n, obs_co[i], mco[i]);
        end
        if (obs_z[i] !== (mq[i] == 64'd0)) begin
          errors++; $display("FAIL rand_zero inst=%0d cyc=%0d got=%b exp=%b", i, n, obs_z[i], mq[i] == 64'd0);
        end
      end
      $display("rand cyc=%0d cmd=%h d=%h q_a=%h q_b=%h q_c=%b co=%b%b%b", n, cmd, dv, q_a, q_b, q_c, co_a, co_b, co_c);
    end
  endtask

  initial begin
    mw[0] = 16; mw[1] = 16; mw[2] = 1;
    mrv[0] = 64'h0; mrv[1] = 64'h0010; mrv[2] = 64'h1;
    for (int i = 0; i < 3; i++) begin
      mq[i] = 64'd0; mco[i] = 1'b0;
    end
    test_reset();
    test_load();
    test_increment_wrap();
    test_decrement_wrap();
    test_priority();
    test_sync_reset();
    test_shift();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
